mux2_stream_arbiter: RTL and testbench

- Upstream select/feed stage for the 2:1 multiplexer path.
- Arbitrates two valid/ready input streams (channel 0, channel 1) onto one registered output stream, round-robin, one beat per grant.
- Drives `sel` with the channel index of the beat currently held. Downstream MUX2X1 instances and consumers use it to route or tag the data.

---
 rtl/mux2_stream_arbiter_pkg.sv | 15 +
 rtl/mux2_stream_arbiter_rr_grant2.sv | 24 ++
 rtl/mux2x1.sv | 11 +
 rtl/mux2_stream_arbiter.sv | 71 +++++++
 tb/tb_mux2_stream_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux2_stream_arbiter_pkg.sv
// Shared definitions for the two-channel stream arbiter: channel indices and
// the channel-index type that travels on sel.
package mux2_stream_arbiter_pkg;

    typedef logic ch_t;

    localparam ch_t CH0 = 1'b0;
    localparam ch_t CH1 = 1'b1;

    // Round-robin pointer after serving a channel: the other channel goes next.
    function automatic ch_t next_prio(input ch_t served);
        return ~served;
    endfunction

endpackage

// File: rtl/mux2_stream_arbiter_rr_grant2.sv
// Two-requester round-robin picker: a lone requester always wins, and a tie
// goes to whichever channel currently holds priority.
module rr_grant2
    import mux2_stream_arbiter_pkg::*;
(
    input  logic v0,
    input  logic v1,
    input  ch_t  prio,
    output ch_t  grant,
    output logic any
);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = CH0;
        any   = v0 | v1;
        if (v0 && v1) begin
            grant = prio;
        end else if (v1) begin
            grant = CH1;
        end
    end

endmodule

// File: rtl/mux2x1.sv
// Single-bit 2:1 multiplexer cell: y follows a when s = 0, b when s = 1.
module mux2x1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mux2_stream_arbiter.sv
// Round-robin arbiter merging two valid/ready streams into one registered
// output stream; sel tags each held beat with its source channel.
module mux2_stream_arbiter
    import mux2_stream_arbiter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d0_valid,
    input  logic [WIDTH-1:0] d0_data,
    output logic             d0_ready,
    input  logic             d1_valid,
    input  logic [WIDTH-1:0] d1_data,
    output logic             d1_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             sel
);

    ch_t              prio;
    ch_t              grant;
    logic             any_valid;
    logic             free;
    logic             accept;
    logic [WIDTH-1:0] pick_data;

    rr_grant2 u_grant (
        .v0    (d0_valid),
        .v1    (d1_valid),
        .prio  (prio),
        .grant (grant),
        .any   (any_valid)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_pick
        mux2x1 u_mux (
            .a (d0_data[i]),
            .b (d1_data[i]),
            .s (grant),
            .y (pick_data[i])
        );
    end

    assign free   = !y_valid || y_ready;
    assign accept = free && any_valid;

    // Readies are masked by rst_n so nothing is accepted while reset is held.
    assign d0_ready = rst_n && accept && (grant == CH0);
    assign d1_ready = rst_n && accept && (grant == CH1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            sel     <= CH0;
            prio    <= ch_t'(PRIO_INIT);
        end else if (accept) begin
            y_valid <= 1'b1;
            y_data  <= pick_data;
            sel     <= grant;
            prio    <= next_prio(grant);
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Self-checking bench for mux2_stream_arbiter: directed scenarios followed by
// randomized traffic compared against a transaction-level round-robin model.
module tb_mux2_stream_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d0_valid, d1_valid, y_ready;
    logic [7:0] d0_data, d1_data;
    logic       d0_ready, d1_ready, y_valid, sel;
    logic [7:0] y_data;

    int vectors     = 0;
    int miscompares = 0;

    mux2_stream_arbiter #(.WIDTH(8), .PRIO_INIT(1'b0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d0_valid (d0_valid),
        .d0_data  (d0_data),
        .d0_ready (d0_ready),
        .d1_valid (d1_valid),
        .d1_data  (d1_data),
        .d1_ready (d1_ready),
        .y_valid  (y_valid),
        .y_data   (y_data),
        .y_ready  (y_ready),
        .sel      (sel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n    = 1'b0;
        d0_valid = 1'b0;
        d1_valid = 1'b0;
        d0_data  = 8'h00;
        d1_data  = 8'h00;
        y_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        d0_valid = 1'b1;
        d0_data  = 8'hA5;
        d1_valid = 1'b1;
        d1_data  = 8'h5A;
        y_ready  = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (y_valid !== 1'b0 || y_data !== 8'h00 || sel !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b data=%h sel=%b, want 0/00/0", y_valid, y_data, sel);
        end
        vectors++;
        if (d0_ready !== 1'b0 || d1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_readys: got d0_ready=%b d1_ready=%b, want 0/0", d0_ready, d1_ready);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (d0_ready !== 1'b1 || d1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first_grant: got d0_ready=%b d1_ready=%b, want 1/0", d0_ready, d1_ready);
        end
        d1_valid = 1'b0;
        tick();
        d0_valid = 1'b0;
        vectors++;
        if (y_valid !== 1'b1 || y_data !== 8'hA5 || sel !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first_beat: got valid=%b data=%h sel=%b, want 1/a5/0", y_valid, y_data, sel);
        end
        tick();
    endtask

    task automatic test_fair_alternation();
        logic [7:0] q0[$] = '{8'h10, 8'h11, 8'h12};
        logic [7:0] q1[$] = '{8'h20, 8'h21, 8'h22};
        logic [7:0] exp_data[6] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
        logic [7:0] got_data[$];
        logic       got_sel[$];
        int         got_cyc[$];
        reset_dut();
        y_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            d0_valid = (q0.size() != 0);
            d0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
            d1_valid = (q1.size() != 0);
            d1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
            @(negedge clk);
            if (y_valid && y_ready) begin
                got_data.push_back(y_data);
                got_sel.push_back(sel);
                got_cyc.push_back(c);
            end
            if (d0_valid && d0_ready) void'(q0.pop_front());
            if (d1_valid && d1_ready) void'(q1.pop_front());
            tick();
        end
        vectors++;
        if (got_data.size() != 6) begin
            miscompares++;
            $display("FAIL fair_count: got %0d beats, want 6", got_data.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (got_data[i] !== exp_data[i] || got_sel[i] !== i[0]) begin
                    miscompares++;
                    $display("FAIL fair_beat%0d: got data=%h sel=%b, want %h/%b", i, got_data[i], got_sel[i], exp_data[i], i[0]);
                end
            end
            vectors++;
            if (got_cyc[5] - got_cyc[0] != 5) begin
                miscompares++;
                $display("FAIL fair_no_bubble: got span %0d cycles, want 5", got_cyc[5] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        d0_valid = 1'b1;
        d0_data  = 8'h33;
        tick();
        d0_data  = 8'h55;
        d1_valid = 1'b1;
        d1_data  = 8'h44;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (y_valid !== 1'b1 || y_data !== 8'h33 || sel !== 1'b0 || d0_ready !== 1'b0 || d1_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got valid=%b data=%h sel=%b rdy=%b%b, want 1/33/0 rdy=00",
                         c, y_valid, y_data, sel, d0_ready, d1_ready);
            end
            tick();
        end
        y_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (d0_ready !== 1'b0 || d1_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release_grant: got rdy=%b%b, want 01", d0_ready, d1_ready);
        end
        tick();
        d1_valid = 1'b0;
        vectors++;
        if (y_valid !== 1'b1 || y_data !== 8'h44 || sel !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_reload: got valid=%b data=%h sel=%b, want 1/44/1", y_valid, y_data, sel);
        end
        tick();
        d0_valid = 1'b0;
        vectors++;
        if (y_valid !== 1'b1 || y_data !== 8'h55 || sel !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_next: got valid=%b data=%h sel=%b, want 1/55/0", y_valid, y_data, sel);
        end
        tick();
    endtask

    task automatic test_single_channel();
        reset_dut();
        y_ready  = 1'b1;
        d1_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            d1_data = 8'(i);
            @(negedge clk);
            vectors++;
            if (d1_ready !== 1'b1 || d0_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL single_ready%0d: got rdy=%b%b, want 01", i, d0_ready, d1_ready);
            end
            tick();
            vectors++;
            if (y_valid !== 1'b1 || y_data !== 8'(i) || sel !== 1'b1) begin
                miscompares++;
                $display("FAIL single_beat%0d: got valid=%b data=%h sel=%b, want 1/%h/1", i, y_valid, y_data, sel, 8'(i));
            end
        end
        d1_data  = 8'h05;
        d0_valid = 1'b1;
        d0_data  = 8'hC0;
        @(negedge clk);
        vectors++;
        if (d0_ready !== 1'b1 || d1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL single_then_d0: got rdy=%b%b, want 10", d0_ready, d1_ready);
        end
        tick();
        d0_valid = 1'b0;
        d1_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        reset_dut();
        d0_valid = 1'b1;
        d0_data  = 8'h66;
        tick();
        d0_valid = 1'b0;
        vectors++;
        if (y_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL async_prefill: got valid=%b, want 1", y_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (y_valid !== 1'b0 || y_data !== 8'h00 || sel !== 1'b0) begin
            miscompares++;
            $display("FAIL async_drop: got valid=%b data=%h sel=%b, want 0/00/0", y_valid, y_data, sel);
        end
        @(negedge clk);
        d0_valid = 1'b1;
        d1_valid = 1'b1;
        d1_data  = 8'h77;
        rst_n    = 1'b1;
        #1;
        vectors++;
        if (d0_ready !== 1'b1 || d1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL async_prio_init: got rdy=%b%b, want 10", d0_ready, d1_ready);
        end
        tick();
        d0_valid = 1'b0;
        d1_valid = 1'b0;
        tick();
    endtask

    task automatic test_idle();
        reset_dut();
        y_ready  = 1'b1;
        d0_valid = 1'b1;
        d0_data  = 8'h7E;
        tick();
        d0_valid = 1'b0;
        tick();
        for (int c = 0; c < 2; c++) begin
            vectors++;
            if (y_valid !== 1'b0 || y_data !== 8'h7E || sel !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_hold%0d: got valid=%b data=%h sel=%b, want 0/7e/0", c, y_valid, y_data, sel);
            end
            tick();
        end
    endtask

    // Transaction-level model: register contents plus the last channel served.
    task automatic test_random();
        logic       m_full = 1'b0;
        logic [7:0] m_data = 8'h00;
        logic       m_sel  = 1'b0;
        logic       m_last = 1'b1;
        logic       want_r0, want_r1, go, pick;
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            if (!d0_valid && ($urandom_range(0, 3) != 0)) begin
                d0_valid = 1'b1;
                d0_data  = 8'($urandom);
            end
            if (!d1_valid && ($urandom_range(0, 3) != 0)) begin
                d1_valid = 1'b1;
                d1_data  = 8'($urandom);
            end
            y_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            go      = (!m_full || y_ready) && (d0_valid || d1_valid);
            pick    = (d0_valid && d1_valid) ? !m_last : d1_valid;
            want_r0 = go && (pick == 1'b0);
            want_r1 = go && (pick == 1'b1);
            vectors++;
            if (d0_ready !== want_r0 || d1_ready !== want_r1) begin
                miscompares++;
                $display("FAIL rand_ready c%0d: got rdy=%b%b, want %b%b", c, d0_ready, d1_ready, want_r0, want_r1);
            end
            vectors++;
            if (y_valid !== m_full || y_data !== m_data || sel !== m_sel) begin
                miscompares++;
                $display("FAIL rand_out c%0d: got valid=%b data=%h sel=%b, want %b/%h/%b",
                         c, y_valid, y_data, sel, m_full, m_data, m_sel);
            end
            if (go) begin
                m_full = 1'b1;
                m_data = pick ? d1_data : d0_data;
                m_sel  = pick;
                m_last = pick;
            end else if (y_ready) begin
                m_full = 1'b0;
            end
            tick();
            if (want_r0) d0_valid = 1'b0;
            if (want_r1) d1_valid = 1'b0;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        d0_valid = 1'b0;
        d1_valid = 1'b0;
        d0_data  = 8'h00;
        d1_data  = 8'h00;
        y_ready  = 1'b0;
        test_reset();
        test_fair_alternation();
        test_backpressure();
        test_single_channel();
        test_async_reset();
        test_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
